aes128_dec_sequencer: RTL and testbench

- Iterative AES-128 decryption controller. Sequences one inverse round per clock through a shared round datapath.
- Fetches round keys from an external key store, most recent key first.
- Wraps the existing inv_mix_columns datapath with valid/ready handshakes on both input and output.
- Sits between the ciphertext ingress buffer and the plaintext egress path of the decryption pipeline.

---
 rtl/aes_dec_pkg.sv | 56 +++++
 rtl/aes_inv_round.sv | 24 ++
 rtl/inv_mix_columns.sv | 43 ++++
 rtl/aes128_dec_sequencer.sv | 125 ++++++++++++
 tb/tb_aes128_dec_sequencer.sv | 332 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/aes_dec_pkg.sv
// Shared definitions for the iterative AES-128 decryption sequencer:
// round constants, FSM encoding, inverse S-box and the byte-permutation helpers.
package aes_dec_pkg;

  localparam int NR       = 10;
  localparam int RK_IDX_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ROUND = 2'd1,
    ST_FINAL = 2'd2,
    ST_DONE  = 2'd3
  } dec_state_e;

  localparam logic [7:0] INV_SBOX [256] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };

  // Byte (row r, column c) lives at byte index 4c+r, i.e. bits [127-8*(4c+r) -: 8].
  // Row r is rotated right by r columns.
  function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
    logic [127:0] r;
    r = '0;
    for (int c = 0; c < 4; c++) begin
      for (int row = 0; row < 4; row++) begin
        r[127-8*(4*c+row) -: 8] = s[127-8*(4*((c+4-row)%4)+row) -: 8];
      end
    end
    return r;
  endfunction

  function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
    logic [127:0] r;
    r = '0;
    for (int i = 0; i < 16; i++) begin
      r[127-8*i -: 8] = INV_SBOX[s[127-8*i -: 8]];
    end
    return r;
  endfunction

endpackage

// File: rtl/aes_inv_round.sv
// One combinational inverse round: InvShiftRows, InvSubBytes, AddRoundKey,
// then InvMixColumns unless this is the last round.
module aes_inv_round
  import aes_dec_pkg::*;
(
  input  logic [127:0] state_in,
  input  logic [127:0] round_key,
  input  logic         last,
  output logic [127:0] state_out
);

  logic [127:0] pre_mix;
  logic [127:0] mixed;

  assign pre_mix = inv_sub_bytes(inv_shift_rows(state_in)) ^ round_key;

  inv_mix_columns u_inv_mix_columns (
    .state_in  (pre_mix),
    .state_out (mixed)
  );

  assign state_out = last ? pre_mix : mixed;

endmodule

// File: rtl/inv_mix_columns.sv
// InvMixColumns over a full 128-bit state; each 32-bit column is multiplied
// by the fixed {0e,0b,0d,09} circulant matrix in GF(2^8).
module inv_mix_columns (
  input  logic [127:0] state_in,
  output logic [127:0] state_out
);

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
    logic [7:0] a  [4];
    logic [7:0] m9 [4];
    logic [7:0] mb [4];
    logic [7:0] md [4];
    logic [7:0] me [4];
    logic [7:0] x2, x4, x8;
    for (int i = 0; i < 4; i++) begin
      a[i]  = col[31-8*i -: 8];
      x2    = xtime(a[i]);
      x4    = xtime(x2);
      x8    = xtime(x4);
      m9[i] = x8 ^ a[i];
      mb[i] = x8 ^ x2 ^ a[i];
      md[i] = x8 ^ x4 ^ a[i];
      me[i] = x8 ^ x4 ^ x2;
    end
    return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
            m9[0] ^ me[1] ^ mb[2] ^ md[3],
            md[0] ^ m9[1] ^ me[2] ^ mb[3],
            mb[0] ^ md[1] ^ m9[2] ^ me[3]};
  endfunction

  // Column-wise matrix multiply.
  always_comb begin
    state_out = '0;
    for (int c = 0; c < 4; c++) begin
      state_out[127-32*c -: 32] = inv_mix_col(state_in[127-32*c -: 32]);
    end
  end

endmodule

// File: rtl/aes128_dec_sequencer.sv
// Iterative AES-128 decryption: one inverse round per clock through a single
// shared round datapath, round keys fetched newest first from an external store.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. Ciphertext is taken in IDLE, or in DONE while the previous
// plaintext drains (in_ready follows out_ready there). out_data is held
// stable while out_valid is high until out_ready is seen.
module aes128_dec_sequencer #(
  parameter int NR       = aes_dec_pkg::NR,
  parameter int RK_IDX_W = aes_dec_pkg::RK_IDX_W
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [127:0]        in_data,
  output logic [RK_IDX_W-1:0] rk_idx,
  input  logic [127:0]        rk_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [127:0]        out_data,
  output logic                busy,
  output logic [1:0]          dbg_state
);

  if (NR != 10) begin : g_nr_check
    $error("aes128_dec_sequencer: only NR=10 is supported");
  end

  localparam logic [RK_IDX_W-1:0] RK_TOP   = RK_IDX_W'(NR);
  localparam logic [RK_IDX_W-1:0] RK_FIRST = RK_IDX_W'(NR - 1);
  localparam logic [RK_IDX_W-1:0] RK_ONE   = RK_IDX_W'(1);

  aes_dec_pkg::dec_state_e state_q, state_d;
  logic [127:0]            blk_q, blk_d;
  logic [RK_IDX_W-1:0]     rnd_q, rnd_d;
  logic [127:0]            out_data_q, out_data_d;
  logic                    out_valid_q, out_valid_d;
  logic                    last;
  logic [127:0]            round_out;

  aes_inv_round u_aes_inv_round (
    .state_in  (blk_q),
    .round_key (rk_data),
    .last      (last),
    .state_out (round_out)
  );

  // State and datapath registers; reset discards any block in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= aes_dec_pkg::ST_IDLE;
      blk_q       <= '0;
      rnd_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      blk_q       <= blk_d;
      rnd_q       <= rnd_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
    end
  end

  // Next-state, key index and handshake logic.
  always_comb begin
    state_d     = state_q;
    blk_d       = blk_q;
    rnd_d       = rnd_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    in_ready    = 1'b0;
    rk_idx      = RK_TOP;
    last        = 1'b0;
    case (state_q)
      aes_dec_pkg::ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          blk_d   = in_data ^ rk_data;
          rnd_d   = RK_FIRST;
          state_d = aes_dec_pkg::ST_ROUND;
        end
      end
      aes_dec_pkg::ST_ROUND: begin
        rk_idx = rnd_q;
        blk_d  = round_out;
        if (rnd_q == RK_ONE) state_d = aes_dec_pkg::ST_FINAL;
        else                 rnd_d   = rnd_q - RK_ONE;
      end
      aes_dec_pkg::ST_FINAL: begin
        rk_idx      = '0;
        last        = 1'b1;
        out_data_d  = round_out;
        out_valid_d = 1'b1;
        state_d     = aes_dec_pkg::ST_DONE;
      end
      aes_dec_pkg::ST_DONE: begin
        // Key NR is already on rk_data so a new block can load while draining.
        in_ready = out_ready;
        if (out_ready) begin
          out_valid_d = 1'b0;
          if (in_valid) begin
            blk_d   = in_data ^ rk_data;
            rnd_d   = RK_FIRST;
            state_d = aes_dec_pkg::ST_ROUND;
          end else begin
            state_d = aes_dec_pkg::ST_IDLE;
          end
        end
      end
      default: state_d = aes_dec_pkg::ST_IDLE;
    endcase
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign busy      = (state_q == aes_dec_pkg::ST_ROUND) || (state_q == aes_dec_pkg::ST_FINAL);
  assign dbg_state = state_q;

  // The countdown must stay within 1..NR-1 while rounds are running.
  assert property (@(posedge clk) disable iff (!rst_n)
    (state_q == aes_dec_pkg::ST_ROUND) |-> (rnd_q != '0 && rnd_q != RK_TOP));

endmodule

// File: tb/tb_aes128_dec_sequencer.sv
// Bench for aes128_dec_sequencer: key store model, forward-cipher reference
// built from GF(2^8) arithmetic, expected-plaintext queue and output monitor.
module tb_aes128_dec_sequencer;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid, in_ready, out_valid, out_ready, busy;
  logic [127:0] in_data, rk_data, out_data;
  logic [3:0]   rk_idx;
  logic [1:0]   dbg_state;

  logic [127:0] rk_tab [11];
  logic [7:0]   sbox [256];
  int           errors = 0;
  int           checks = 0;
  int           cyc = 0;
  logic [127:0] exp_q [$];
  int           acc_q [$];
  logic [127:0] cur_exp;
  logic         prev_ov = 1'b0;

  localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;

  aes128_dec_sequencer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .rk_idx    (rk_idx),
    .rk_data   (rk_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy),
    .dbg_state (dbg_state)
  );

  // Clock and cycle counter.
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Key store: combinational lookup.
  assign rk_data = (rk_idx <= 4'd10) ? rk_tab[rk_idx] : 128'h0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xt(x);
    end
    return p;
  endfunction

  // Forward S-box: multiplicative inverse followed by the affine map.
  task automatic build_sbox();
    logic [7:0] inv, b;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++) if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      b = inv;
      sbox[x] = b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
    end
  endtask

  task automatic expand_key(input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t  = {t[23:0], t[31:24]};
        t  = {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]} ^ {rc, 24'h0};
        rc = xt(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) rk_tab[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  // Forward cipher with the current key table; the DUT must invert it.
  function automatic logic [127:0] encrypt(input logic [127:0] pt);
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [127:0] v;
    v = pt ^ rk_tab[0];
    for (int r = 1; r <= 10; r++) begin
      for (int i = 0; i < 16; i++) s[i] = sbox[v[127-8*i -: 8]];
      for (int c = 0; c < 4; c++)
        for (int rw = 0; rw < 4; rw++) t[4*c+rw] = s[4*((c+rw)%4)+rw];
      if (r != 10) begin
        for (int c = 0; c < 4; c++) begin
          s[4*c]   = gmul(t[4*c], 8'h02) ^ gmul(t[4*c+1], 8'h03) ^ t[4*c+2] ^ t[4*c+3];
          s[4*c+1] = t[4*c] ^ gmul(t[4*c+1], 8'h02) ^ gmul(t[4*c+2], 8'h03) ^ t[4*c+3];
          s[4*c+2] = t[4*c] ^ t[4*c+1] ^ gmul(t[4*c+2], 8'h02) ^ gmul(t[4*c+3], 8'h03);
          s[4*c+3] = gmul(t[4*c], 8'h03) ^ t[4*c+1] ^ t[4*c+2] ^ gmul(t[4*c+3], 8'h02);
        end
      end else begin
        s = t;
      end
      for (int i = 0; i < 16; i++) v[127-8*i -: 8] = s[i] ^ rk_tab[r][127-8*i -: 8];
    end
    return v;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Driver: present one block, return 2 time units after the accepting edge.
  task automatic send(input logic [127:0] ct, input logic [127:0] exp);
    int n;
    n        = 0;
    in_valid = 1'b1;
    in_data  = ct;
    cur_exp  = exp;
    do begin
      @(negedge clk);
      n++;
    end while (!in_ready && n < 200);
    if (!in_ready) begin
      errors++;
      checks++;
      $display("FAIL send_timeout: in_ready stayed 0 for %0d cycles", n);
    end
    @(posedge clk);
    #2;
    in_valid = 1'b0;
    in_data  = rand128();
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(posedge clk);
      #2;
      n++;
    end
    if (exp_q.size() != 0) begin
      errors++;
      checks++;
      $display("FAIL drain_timeout: %0d blocks still pending", exp_q.size());
    end
  endtask

  // Monitor: records acceptances, checks latency on out_valid rise and
  // compares plaintext on each output handshake.
  always @(negedge clk) begin
    if (rst_n) begin
      if (in_valid && in_ready) begin
        exp_q.push_back(cur_exp);
        acc_q.push_back(cyc + 1);
      end
      if (out_valid && !prev_ov) begin
        if (acc_q.size() == 0) chk("latency_orphan", 128'(out_valid), 128'(0));
        else                   chk("latency", 128'(cyc - acc_q[0]), 128'(10));
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_output", out_data, 128'hx);
        end else begin
          chk("plaintext", out_data, exp_q.pop_front());
          void'(acc_q.pop_front());
        end
      end
    end
    prev_ov = out_valid;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] pt, pt2;
    int n;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
    cur_exp   = '0;
    for (int r = 0; r < 11; r++) rk_tab[r] = '0;
    build_sbox();

    // Reset values.
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready",  128'(in_ready),  128'(1));
    chk("rst_out_valid", 128'(out_valid), 128'(0));
    chk("rst_out_data",  out_data,        128'(0));
    chk("rst_busy",      128'(busy),      128'(0));
    chk("rst_rk_idx",    128'(rk_idx),    128'(10));
    @(posedge clk);
    #2;
    rst_n = 1'b1;

    // FIPS-197 C.1.
    expand_key(C1_KEY);
    send(C1_CT, C1_PT);
    wait_drain();

    // FIPS-197 Appendix B with round-key index sequence.
    expand_key(B_KEY);
    @(negedge clk);
    chk("rk_idx_idle", 128'(rk_idx), 128'(10));
    @(posedge clk);
    #2;
    send(B_CT, B_PT);
    for (int k = 9; k >= 0; k--) begin
      @(negedge clk);
      chk("rk_idx_seq", 128'(rk_idx), 128'(k));
    end
    @(negedge clk);
    chk("rk_idx_done", 128'(rk_idx), 128'(10));
    wait_drain();

    // Backpressure on the output with a second block waiting.
    expand_key(rand128());
    out_ready = 1'b0;
    pt = rand128();
    send(encrypt(pt), pt);
    n = 0;
    while (!out_valid && n < 50) begin
      @(posedge clk);
      #2;
      n++;
    end
    chk("bp_out_valid_rise", 128'(out_valid), 128'(1));
    pt2      = rand128();
    in_valid = 1'b1;
    in_data  = encrypt(pt2);
    cur_exp  = pt2;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_out_data",  out_data,           pt);
      chk("bp_in_ready",  128'(in_ready),     128'(0));
      chk("bp_out_valid", 128'(out_valid),    128'(1));
    end
    @(posedge clk);
    #2;
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_release", 128'({in_ready, out_valid}), 128'(2'b11));
    @(posedge clk);
    #2;
    in_valid = 1'b0;
    @(negedge clk);
    chk("bp_second_busy", 128'(busy), 128'(1));
    @(posedge clk);
    #2;
    wait_drain();

    // Back-to-back blocks with out_ready held high.
    expand_key(rand128());
    for (int b = 0; b < 4; b++) begin
      pt = rand128();
      send(encrypt(pt), pt);
    end
    wait_drain();

    // Asynchronous reset in the middle of round 5.
    expand_key(C1_KEY);
    send(C1_CT, C1_PT);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (rk_idx != 4'd5 && n < 20);
    chk("reached_round5", 128'(rk_idx), 128'(5));
    #1;
    rst_n = 1'b0;
    #1;
    chk("arst_in_ready",  128'(in_ready),  128'(1));
    chk("arst_out_valid", 128'(out_valid), 128'(0));
    chk("arst_out_data",  out_data,        128'(0));
    chk("arst_busy",      128'(busy),      128'(0));
    chk("arst_rk_idx",    128'(rk_idx),    128'(10));
    exp_q.delete();
    acc_q.delete();
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    send(C1_CT, C1_PT);
    wait_drain();

    // Junk requests while rounds are running must not disturb the block.
    pt = rand128();
    send(encrypt(pt), pt);
    cur_exp = ~pt;
    for (int i = 0; i < 7; i++) begin
      in_valid = 1'b1;
      in_data  = rand128();
      @(posedge clk);
      #2;
    end
    in_valid = 1'b0;
    wait_drain();
    repeat (3) @(posedge clk);
    #2;
    chk("queue_empty", 128'(exp_q.size()), 128'(0));
    chk("final_idle_ready", 128'(in_ready), 128'(1));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
